// File: rtl/sifh_frame_sequencer_pkg.sv
// ============================================================================
// Module   : sifh_pkg
// Purpose  : Shared types and constants for the SiFH frame sequencer slice:
//            the sequencer state encoding, default geometry parameters, and
//            the counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sifh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR0   = 3'd1,
    ST_COARSE = 3'd2,
    ST_PK0    = 3'd3,
    ST_CLR1   = 3'd4,
    ST_FINE   = 3'd5,
    ST_PK1    = 3'd6,
    ST_DONE   = 3'd7
  } seq_state_t;

  localparam int NP_DEF       = 10;
  localparam int NB_DEF       = 6;
  localparam int PIXELS_DEF   = 2;
  localparam int DATA_NUM_DEF = 4;
  localparam int ACQ_NUM_DEF  = 33333;
  localparam int PEAK_LAT_DEF = 4;

  // Bins held by one BRAM (all pixels sharing it).
  localparam int BIN_NUM_PER_RAM = PIXELS_DEF * (2 ** NB_DEF);

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sifh_frame_sequencer_if.sv
// ============================================================================
// Module   : sifh_frame_sequencer_if
// Purpose  : Bundles the frame control, TDC handshake and histogram-builder
//            signals of the SiFH frame sequencer.
//   master : drives start/tdc_valid/tdc_data, observes everything else
//   slave  : the sequencer; drives tdc_ready, hb_*, peak_latch, busy,
//            frame_done
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sifh_frame_sequencer_if
  import sifh_pkg::*;
#(
  parameter int NP     = NP_DEF,
  parameter int NB     = NB_DEF,
  parameter int PIXELS = PIXELS_DEF
);
  localparam int PW = cnt_w(PIXELS);

  logic          start;
  logic          tdc_valid;
  logic [NP-1:0] tdc_data;
  logic          tdc_ready;
  logic          hb_wr_en;
  logic [NP-1:0] hb_data;
  logic [PW-1:0] hb_pixel;
  logic          hb_pass;
  logic          hb_clr_en;
  logic [PW+NB-1:0] hb_clr_addr;
  logic          peak_latch;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, tdc_valid, tdc_data,
    input  tdc_ready, hb_wr_en, hb_data, hb_pixel, hb_pass, hb_clr_en,
           hb_clr_addr, peak_latch, busy, frame_done
  );

  modport slave (
    input  start, tdc_valid, tdc_data,
    output tdc_ready, hb_wr_en, hb_data, hb_pixel, hb_pass, hb_clr_en,
           hb_clr_addr, peak_latch, busy, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/sifh_frame_sequencer_counter.sv
// ============================================================================
// Module   : sifh_seq_counter
// Purpose  : Cascaded sample -> pixel -> acquisition counter for one pass.
//   clk, res : clock, synchronous active-low reset
//   i_inc    : count one accepted sample
//   i_clr    : return all counters to zero (wins over i_inc)
//   o_pixel  : current pixel index
//   o_last   : all three counters at their terminal values
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sifh_seq_counter
  import sifh_pkg::*;
#(
  parameter int DATA_NUM = DATA_NUM_DEF,
  parameter int PIXELS   = PIXELS_DEF,
  parameter int ACQ_NUM  = ACQ_NUM_DEF
) (
  input  wire logic                        clk,
  input  wire logic                        res,
  input  wire logic                        i_inc,
  input  wire logic                        i_clr,
  output logic [cnt_w(PIXELS)-1:0]         o_pixel,
  output logic                             o_last
);
  localparam int SW = cnt_w(DATA_NUM);
  localparam int PW = cnt_w(PIXELS);
  localparam int AW = cnt_w(ACQ_NUM);
  localparam logic [SW-1:0] C_SMP_MAX = SW'(DATA_NUM - 1);
  localparam logic [PW-1:0] C_PIX_MAX = PW'(PIXELS - 1);
  localparam logic [AW-1:0] C_ACQ_MAX = AW'(ACQ_NUM - 1);

  logic [SW-1:0] r_smp;
  logic [PW-1:0] r_pix;
  logic [AW-1:0] r_acq;
  logic          w_smp_max;
  logic          w_pix_max;
  logic          w_acq_max;

  // Terminal compares instead of natural overflow: counts need not be 2^n.
  assign w_smp_max = (r_smp == C_SMP_MAX);
  assign w_pix_max = (r_pix == C_PIX_MAX);
  assign w_acq_max = (r_acq == C_ACQ_MAX);
  assign o_last    = w_smp_max & w_pix_max & w_acq_max;
  assign o_pixel   = r_pix;

  always_ff @(posedge clk) begin
    if (!res || i_clr) begin
      r_smp <= '0;
      r_pix <= '0;
      r_acq <= '0;
    end else if (i_inc) begin
      if (!w_smp_max) begin
        r_smp <= r_smp + 1'b1;
      end else begin
        r_smp <= '0;
        if (!w_pix_max) begin
          r_pix <= r_pix + 1'b1;
        end else begin
          r_pix <= '0;
          r_acq <= w_acq_max ? '0 : r_acq + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sifh_frame_sequencer.sv
// ============================================================================
// Module   : sifh_frame_sequencer
// Purpose  : Frame controller for the SiFH histogram builder. Runs each frame
//            as clear / coarse pass / peak drain / clear / fine pass / peak
//            drain, tagging accepted TDC samples with pixel and pass.
//   clk   : system clock
//   res   : synchronous active-low reset
//   bus   : sifh_frame_sequencer_if.slave (start, TDC handshake, hb_* outputs,
//           peak_latch, busy, frame_done)
//   abort : only when SIFH_SEQ_ABORT_EN is defined; returns to IDLE at once
// Config   : `define SIFH_SEQ_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sifh_frame_sequencer
  import sifh_pkg::*;
#(
  parameter int NP       = NP_DEF,
  parameter int NB       = NB_DEF,
  parameter int PIXELS   = PIXELS_DEF,
  parameter int DATA_NUM = DATA_NUM_DEF,
  parameter int ACQ_NUM  = ACQ_NUM_DEF,
  parameter int PEAK_LAT = PEAK_LAT_DEF
) (
  input  wire logic              clk,
  input  wire logic              res,
  sifh_frame_sequencer_if.slave  bus
`ifdef SIFH_SEQ_ABORT_EN
  ,
  input  wire logic              abort
`endif
);
  localparam int PW = cnt_w(PIXELS);
  localparam int CW = PW + NB;
  localparam int LW = cnt_w(PEAK_LAT + 1);
  localparam logic [CW-1:0] C_CLR_LAST = CW'(PIXELS * (2 ** NB) - 1);
  localparam logic [LW-1:0] C_PK_LAST  = LW'(PEAK_LAT);

  seq_state_t    r_state;
  logic [CW-1:0] r_clr_addr;
  logic [LW-1:0] r_pk_cnt;
  logic          r_ready;
  logic          r_wr_en;
  logic [NP-1:0] r_data;
  logic [PW-1:0] r_pixel;
  logic          r_pass;
  logic          r_clr_en;
  logic          r_peak;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_cnt_last;
  logic          w_last;
  logic          w_abort;
  logic [PW-1:0] w_pixel;

  // r_ready is high exactly in COARSE/FINE, so it doubles as the pass gate.
  assign w_accept = r_ready & bus.tdc_valid;
  assign w_last   = w_accept & w_cnt_last;

`ifdef SIFH_SEQ_ABORT_EN
  assign w_abort = abort & (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  sifh_seq_counter #(
    .DATA_NUM (DATA_NUM),
    .PIXELS   (PIXELS),
    .ACQ_NUM  (ACQ_NUM)
  ) u_cnt (
    .clk     (clk),
    .res     (res),
    .i_inc   (w_accept),
    .i_clr   (w_last | w_abort),
    .o_pixel (w_pixel),
    .o_last  (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_pk_cnt   <= '0;
      r_ready    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_pixel    <= '0;
      r_pass     <= 1'b0;
      r_clr_en   <= 1'b0;
      r_peak     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_peak  <= 1'b0;
      r_done  <= 1'b0;

      // Tag with the pre-increment pixel and the current pass.
      if (w_accept) begin
        r_wr_en <= 1'b1;
        r_data  <= bus.tdc_data;
        r_pixel <= w_pixel;
        r_pass  <= (r_state == ST_FINE);
      end

      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_wr_en    <= 1'b0;
        r_ready    <= 1'b0;
        r_clr_en   <= 1'b0;
        r_clr_addr <= '0;
        r_pk_cnt   <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state    <= ST_CLR0;
              r_clr_en   <= 1'b1;
              r_clr_addr <= '0;
              r_busy     <= 1'b1;
            end
          end
          ST_CLR0, ST_CLR1: begin
            if (r_clr_addr == C_CLR_LAST) begin
              r_clr_en   <= 1'b0;
              r_clr_addr <= '0;
              r_ready    <= 1'b1;
              r_state    <= (r_state == ST_CLR0) ? ST_COARSE : ST_FINE;
            end else begin
              r_clr_addr <= r_clr_addr + 1'b1;
            end
          end
          ST_COARSE, ST_FINE: begin
            if (w_last) begin
              r_ready  <= 1'b0;
              r_pk_cnt <= '0;
              r_state  <= (r_state == ST_COARSE) ? ST_PK0 : ST_PK1;
            end
          end
          ST_PK0, ST_PK1: begin
            // PEAK_LAT full drain cycles, then the latch pulse on the next edge.
            if (r_pk_cnt == C_PK_LAST) begin
              r_pk_cnt <= '0;
              r_peak   <= 1'b1;
              if (r_state == ST_PK0) begin
                r_state    <= ST_CLR1;
                r_clr_en   <= 1'b1;
                r_clr_addr <= '0;
              end else begin
                r_state <= ST_DONE;
              end
            end else begin
              r_pk_cnt <= r_pk_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.tdc_ready   = r_ready;
  assign bus.hb_wr_en    = r_wr_en;
  assign bus.hb_data     = r_data;
  assign bus.hb_pixel    = r_pixel;
  assign bus.hb_pass     = r_pass;
  assign bus.hb_clr_en   = r_clr_en;
  assign bus.hb_clr_addr = r_clr_addr;
  assign bus.peak_latch  = r_peak;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sifh_frame_sequencer.sv
// ============================================================================
// Module   : tb_sifh_frame_sequencer
// Purpose  : Self-checking bench for sifh_frame_sequencer with a small frame
//            geometry (NB=2, PIXELS=2, DATA_NUM=2, ACQ_NUM=3, PEAK_LAT=3).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sifh_frame_sequencer;
  import sifh_pkg::*;

  localparam int NP = 10, NB = 2, PIXELS = 2, DATA_NUM = 2, ACQ_NUM = 3, PEAK_LAT = 3;
  localparam int C         = PIXELS * (2 ** NB);
  localparam int SPP       = DATA_NUM * PIXELS * ACQ_NUM;
  localparam int FRAME_LEN = 2 * (C + SPP + PEAK_LAT + 1) + 2;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic tb_abort = 1'b0;

  sifh_frame_sequencer_if #(.NP(NP), .NB(NB), .PIXELS(PIXELS)) bus ();

  sifh_frame_sequencer #(
    .NP(NP), .NB(NB), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM),
    .ACQ_NUM(ACQ_NUM), .PEAK_LAT(PEAK_LAT)
  ) dut (
    .clk   (clk),
    .res   (res),
    .bus   (bus.slave)
`ifdef SIFH_SEQ_ABORT_EN
    ,
    .abort (tb_abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] data;
    logic          pix;
    logic          pass;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pk_q[$];
  int   clr0_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   acc_in_frame = 0, exp_clr_addr = 0;
  int   n_wr0 = 0, n_wr1 = 0, n_clr = 0, n_done = 0;
  int   last_wr0 = 0, last_wr1 = 0, done_cyc = 0;
  bit   last_acc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: accepts push the expected write, hb_wr_en pops and compares.
  always @(negedge clk) begin
    last_acc = 1'b0;
    if (res) begin
      if (bus.hb_wr_en) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got write data=%0d at cycle %0d, expected none", bus.hb_data, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (bus.hb_data !== mon_e.data || bus.hb_pixel !== mon_e.pix ||
              bus.hb_pass !== mon_e.pass || cyc !== mon_e.due) begin
            errors++;
            $display("FAIL wr_content: got data=%0d pix=%0d pass=%0d cyc=%0d expected data=%0d pix=%0d pass=%0d cyc=%0d",
                     bus.hb_data, bus.hb_pixel, bus.hb_pass, cyc, mon_e.data, mon_e.pix, mon_e.pass, mon_e.due);
          end
        end
        if (bus.hb_pass) begin n_wr1++; last_wr1 = cyc; end
        else begin n_wr0++; last_wr0 = cyc; end
      end
      if (bus.hb_clr_en) begin
        checks++;
        if (bus.hb_clr_addr !== exp_clr_addr[NB:0] || bus.hb_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL clr_addr: got addr=%0d wr=%0d expected addr=%0d wr=0", bus.hb_clr_addr, bus.hb_wr_en, exp_clr_addr);
        end
        if (exp_clr_addr == 0) clr0_q.push_back(cyc);
        exp_clr_addr = (exp_clr_addr + 1) % C;
        n_clr++;
      end
      if (!bus.busy || bus.hb_clr_en || bus.peak_latch) begin
        checks++;
        if (bus.tdc_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_blocked: got tdc_ready=%0d expected 0 at cycle %0d", bus.tdc_ready, cyc);
        end
      end
      if (bus.peak_latch) pk_q.push_back(cyc);
      if (bus.frame_done) begin n_done++; done_cyc = cyc; end
      if (bus.tdc_valid && bus.tdc_ready && !tb_abort) begin
        mon_e.data = bus.tdc_data;
        mon_e.pix  = 1'(((acc_in_frame % SPP) / DATA_NUM) % PIXELS);
        mon_e.pass = (acc_in_frame >= SPP);
        mon_e.due  = cyc + 1;
        sb_q.push_back(mon_e);
        acc_in_frame = (acc_in_frame + 1) % (2 * SPP);
        last_acc = 1'b1;
      end
    end
  end

  task automatic model_clear();
    sb_q.delete();
    acc_in_frame = 0;
    exp_clr_addr = 0;
  endtask

  // Drive inputs 1 time unit after the edge; new data only once accepted.
  task automatic step(input bit v, input bit s);
    @(posedge clk); #1;
    if (last_acc || !bus.tdc_valid) bus.tdc_data = NP'($urandom);
    bus.tdc_valid = v;
    bus.start     = s;
  endtask

  task automatic test_reset();
    res = 1'b0; bus.start = 1'b1; bus.tdc_valid = 1'b1; bus.tdc_data = '0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.tdc_ready, bus.hb_wr_en, bus.hb_data, bus.hb_pixel, bus.hb_pass, bus.hb_clr_en,
           bus.hb_clr_addr, bus.peak_latch, bus.busy, bus.frame_done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got ready=%0d wr=%0d data=%0d clr=%0d busy=%0d, expected all 0",
                 bus.tdc_ready, bus.hb_wr_en, bus.hb_data, bus.hb_clr_en, bus.busy);
      end
    end
    bus.start = 1'b0; bus.tdc_valid = 1'b0;
    res = 1'b1;
    model_clear();
    repeat (3) step(1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b0 || bus.hb_clr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: got busy=%0d clr=%0d expected 0 0", bus.busy, bus.hb_clr_en);
    end
  endtask

  task automatic test_full_frame();
    int d0, c0, w0, w1, p0, q0, t0;
    d0 = n_done; c0 = n_clr; w0 = n_wr0; w1 = n_wr1; p0 = pk_q.size(); q0 = clr0_q.size();
    step(1'b1, 1'b1);
    t0 = cyc;
    for (int k = 0; k < FRAME_LEN + 20; k++) begin
      step(1'b1, 1'b0);
      @(negedge clk); #1;
      if (n_done != d0) break;
    end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", n_done - d0); end
    checks++;
    if (done_cyc != t0 + FRAME_LEN) begin errors++; $display("FAIL frame_done_cycle: got %0d expected %0d", done_cyc - t0, FRAME_LEN); end
    checks++;
    if (n_clr - c0 != 2 * C) begin errors++; $display("FAIL clr_count: got %0d expected %0d", n_clr - c0, 2 * C); end
    checks++;
    if (n_wr0 - w0 != SPP || n_wr1 - w1 != SPP) begin
      errors++; $display("FAIL wr_count: got coarse=%0d fine=%0d expected %0d each", n_wr0 - w0, n_wr1 - w1, SPP);
    end
    checks++;
    if (clr0_q.size() - q0 != 2) begin
      errors++; $display("FAIL clr_sweeps: got %0d expected 2", clr0_q.size() - q0);
    end else if (clr0_q[q0] != t0 + 1 || clr0_q[q0+1] != t0 + C + SPP + PEAK_LAT + 2) begin
      errors++; $display("FAIL clr_start: got %0d,%0d expected 1,%0d", clr0_q[q0] - t0, clr0_q[q0+1] - t0, C + SPP + PEAK_LAT + 2);
    end
    checks++;
    if (pk_q.size() - p0 != 2) begin
      errors++; $display("FAIL peak_count: got %0d expected 2", pk_q.size() - p0);
    end else if (pk_q[p0] != last_wr0 + PEAK_LAT + 1 || pk_q[p0+1] != last_wr1 + PEAK_LAT + 1 ||
                 pk_q[p0] != t0 + C + SPP + PEAK_LAT + 2) begin
      errors++; $display("FAIL peak_timing: got %0d,%0d after last writes, expected %0d", pk_q[p0] - last_wr0, pk_q[p0+1] - last_wr1, PEAK_LAT + 1);
    end
    step(1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b0 || sb_q.size() != 0) begin
      errors++; $display("FAIL frame_end_idle: got busy=%0d pending=%0d expected 0 0", bus.busy, sb_q.size());
    end
    model_clear();
  endtask

  task automatic test_backpressure();
    int d0, w0, w1;
    bit v;
    d0 = n_done; w0 = n_wr0; w1 = n_wr1; v = 1'b1;
    step(v, 1'b1);
    for (int k = 0; k < 4 * FRAME_LEN; k++) begin
      v = ~v;
      step(v, 1'b0);
      @(negedge clk); #1;
      if (n_done != d0) break;
    end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL gap_frame_done: got %0d expected 1", n_done - d0); end
    checks++;
    if (n_wr0 - w0 != SPP || n_wr1 - w1 != SPP) begin
      errors++; $display("FAIL gap_wr_count: got coarse=%0d fine=%0d expected %0d each", n_wr0 - w0, n_wr1 - w1, SPP);
    end
    step(1'b0, 1'b0);
    model_clear();
  endtask

  task automatic test_busy_start();
    int d0, w0, w1, p0, t0;
    bit s_c, s_p, s;
    d0 = n_done; w0 = n_wr0; w1 = n_wr1; p0 = pk_q.size(); s_c = 0; s_p = 0;
    step(1'b1, 1'b1);
    t0 = cyc;
    for (int k = 0; k < FRAME_LEN + 20; k++) begin
      s = 1'b0;
      if (!s_c && n_wr0 - w0 == 3) begin s = 1'b1; s_c = 1'b1; end
      else if (!s_p && n_wr1 - w1 == SPP && pk_q.size() - p0 == 1) begin s = 1'b1; s_p = 1'b1; end
      step(1'b1, s);
      @(negedge clk); #1;
      if (n_done != d0) break;
    end
    repeat (FRAME_LEN) step(1'b1, 1'b0);
    checks++;
    if (n_done - d0 != 1 || !s_c || !s_p) begin
      errors++; $display("FAIL busy_start_done: got %0d frame_done (pulses %0d/%0d) expected 1", n_done - d0, s_c, s_p);
    end
    checks++;
    if (done_cyc != t0 + FRAME_LEN || bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_timing: got done at %0d busy=%0d expected %0d busy=0", done_cyc - t0, bus.busy, FRAME_LEN);
    end
    step(1'b0, 1'b0);
    model_clear();
  endtask

  task automatic test_reset_mid_fine();
    int d0, w1;
    d0 = n_done; w1 = n_wr1;
    step(1'b1, 1'b1);
    for (int k = 0; k < FRAME_LEN; k++) begin
      step(1'b1, 1'b0);
      @(negedge clk); #1;
      if (n_wr1 - w1 == 5) break;
    end
    @(posedge clk); #1;
    res = 1'b0;
    @(posedge clk); #1;
    res = 1'b1;
    model_clear();
    checks++;
    if (bus.busy !== 1'b0 || bus.hb_wr_en !== 1'b0 || n_wr1 - w1 != 5) begin
      errors++; $display("FAIL mid_reset_idle: got busy=%0d wr=%0d fine_writes=%0d expected 0 0 5", bus.busy, bus.hb_wr_en, n_wr1 - w1);
    end
    repeat (FRAME_LEN) step(1'b1, 1'b0);
    checks++;
    if (n_done != d0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_done: got %0d frame_done busy=%0d expected 0 0", n_done - d0, bus.busy);
    end
    step(1'b0, 1'b0);
    test_full_frame();
  endtask

`ifdef SIFH_SEQ_ABORT_EN
  task automatic test_abort();
    int d0, p0;
    d0 = n_done; p0 = pk_q.size();
    step(1'b1, 1'b1);
    for (int k = 0; k < FRAME_LEN; k++) begin
      step(1'b1, 1'b0);
      if (bus.tdc_ready && acc_in_frame == SPP - 1) begin
        tb_abort = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    tb_abort = 1'b0;
    bus.tdc_valid = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.tdc_ready !== 1'b0 || bus.hb_wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%0d ready=%0d wr=%0d expected 0 0 0", bus.busy, bus.tdc_ready, bus.hb_wr_en);
    end
    repeat (2 * PEAK_LAT + 4) step(1'b1, 1'b0);
    checks++;
    if (pk_q.size() != p0 || n_done != d0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_suppress: got peaks=%0d dones=%0d expected 0 0", pk_q.size() - p0, n_done - d0);
    end
    step(1'b0, 1'b0);
    model_clear();
    test_full_frame();
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.tdc_valid = 1'b0; bus.tdc_data = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_busy_start();
    test_reset_mid_fine();
`ifdef SIFH_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
